// File: rtl/retire_monitor_if.sv
// Commit-side observation bundle for retire_monitor: per-lane retire
// strobes, pipeline exception code and the external halt request.
interface retire_monitor_if #(
  parameter int WAYS = 2
);
  logic [WAYS-1:0] commit_valid;
  logic [3:0]      error_status;
  logic            ext_halt;

  // Driven by the core (or the bench standing in for it)
  modport master (
    output commit_valid,
    output error_status,
    output ext_halt
  );

  // Observed by the monitor
  modport slave (
    input commit_valid,
    input error_status,
    input ext_halt
  );
endinterface

// File: rtl/retire_monitor.sv
// Retirement / halt monitor. Counts cycles and retired instructions while
// the core runs, watches for errors, lack of progress and external halt
// requests, then drains for a fixed window before freezing all counters.
module retire_monitor #(
  parameter int          WAYS         = 2,
  parameter int          CNT_W        = 64,
  parameter int          WATCHDOG     = 50000,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [15:0] IGNORE_MASK  = 16'h0021,
  // A disabled watchdog still needs a 1-bit idle counter port
  localparam int         IDLE_W       = (WATCHDOG > 0) ? $clog2(WATCHDOG + 1) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  retire_monitor_if.slave      mon,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     instr_count,
  output logic [IDLE_W-1:0]    idle_count,
  output logic [1:0]           state,
  output logic [1:0]           halt_reason,
  output logic [3:0]           halt_code,
  output logic                 halted,
  output logic                 halted_pulse
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [1:0] RSN_NONE  = 2'd0;
  localparam logic [1:0] RSN_ERROR = 2'd1;
  localparam logic [1:0] RSN_WDOG  = 2'd2;
  localparam logic [1:0] RSN_EXT   = 2'd3;

  localparam int POP_W   = $clog2(WAYS + 1);
  localparam int SUM_W   = CNT_W + 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(WATCHDOG);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'((WATCHDOG > 0) ? WATCHDOG - 1 : 0);
  localparam logic [DRAIN_W-1:0] DRAIN_LD  = DRAIN_W'(DRAIN_CYCLES);

  logic [1:0]         state_q,  state_d;
  logic [DRAIN_W-1:0] drain_q,  drain_d;
  logic [CNT_W-1:0]   cycle_q,  cycle_d;
  logic [CNT_W-1:0]   instr_q,  instr_d;
  logic [IDLE_W-1:0]  idle_q,   idle_d;
  logic [1:0]         reason_q, reason_d;
  logic [3:0]         code_q,   code_d;
  logic               halted_q, halted_d;
  logic               pulse_q,  pulse_d;

  logic [POP_W-1:0]   retire_cnt;
  logic               any_retire;
  logic [SUM_W-1:0]   instr_sum;
  logic [CNT_W-1:0]   instr_sat;
  logic [CNT_W-1:0]   cycle_sat;
  logic               trig_err;
  logic               trig_wd;
  logic               trig_ext;

  // Number of lanes retiring this cycle
  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < WAYS; i++) begin
      retire_cnt = retire_cnt + POP_W'(mon.commit_valid[i]);
    end
  end

  assign any_retire = |mon.commit_valid;

  // Saturating increments: counters stick at all-ones instead of wrapping
  assign instr_sum = {1'b0, instr_q} + SUM_W'(retire_cnt);
  assign instr_sat = instr_sum[CNT_W] ? {CNT_W{1'b1}} : instr_sum[CNT_W-1:0];
  assign cycle_sat = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);

  // Halt causes; a retire in the same cycle as the last idle edge defeats the watchdog
  assign trig_err = ~IGNORE_MASK[mon.error_status];
  assign trig_wd  = (WATCHDOG != 0) && (idle_q == IDLE_LAST) && !any_retire;
  assign trig_ext = mon.ext_halt;

  // Next-state and counter update for RUN / DRAIN / HALTED
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    cycle_d  = cycle_q;
    instr_d  = instr_q;
    idle_d   = idle_q;
    reason_d = reason_q;
    code_d   = code_q;
    case (state_q)
      ST_RUN: begin
        cycle_d = cycle_sat;
        instr_d = instr_sat;
        if (any_retire) begin
          idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
          idle_d = idle_q + IDLE_W'(1);
        end
        if (trig_err || trig_wd || trig_ext) begin
          if (trig_err) begin
            reason_d = RSN_ERROR;
            code_d   = mon.error_status;
          end else if (trig_wd) begin
            reason_d = RSN_WDOG;
            code_d   = 4'd0;
          end else begin
            reason_d = RSN_EXT;
            code_d   = 4'd0;
          end
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LD;
          end
        end
      end
      ST_DRAIN: begin
        // Late writebacks still count; the first halt cause stays latched
        cycle_d = cycle_sat;
        instr_d = instr_sat;
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q == DRAIN_W'(1)) begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
    halted_d = (state_d == ST_HALTED);
    pulse_d  = (state_d == ST_HALTED) && (state_q != ST_HALTED);
  end

  // State registers, cleared asynchronously whenever reset is low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      cycle_q  <= '0;
      instr_q  <= '0;
      idle_q   <= '0;
      reason_q <= RSN_NONE;
      code_q   <= 4'd0;
      halted_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      cycle_q  <= cycle_d;
      instr_q  <= instr_d;
      idle_q   <= idle_d;
      reason_q <= reason_d;
      code_q   <= code_d;
      halted_q <= halted_d;
      pulse_q  <= pulse_d;
    end
  end

  assign cycle_count  = cycle_q;
  assign instr_count  = instr_q;
  assign idle_count   = idle_q;
  assign state        = state_q;
  assign halt_reason  = reason_q;
  assign halt_code    = code_q;
  assign halted       = halted_q;
  assign halted_pulse = pulse_q;

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: two instances (drain/watchdog build and a
// narrow-counter, no-drain, no-watchdog build) driven with the same
// stimulus and compared every cycle against a behavioural model.
module tb_retire_monitor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  retire_monitor_if #(.WAYS(2)) bus0 ();
  retire_monitor_if #(.WAYS(2)) bus1 ();

  logic [63:0] cyc0, ins0;
  logic [3:0]  idle0;
  logic [1:0]  st0, rsn0;
  logic [3:0]  code0;
  logic        hl0, pl0;

  logic [3:0]  cyc1, ins1;
  logic        idle1;
  logic [1:0]  st1, rsn1;
  logic [3:0]  code1;
  logic        hl1, pl1;

  retire_monitor #(
    .WAYS(2), .CNT_W(64), .WATCHDOG(8), .DRAIN_CYCLES(4), .IGNORE_MASK(16'h0021)
  ) u0 (
    .clock(clk), .reset(rst_n), .mon(bus0.slave),
    .cycle_count(cyc0), .instr_count(ins0), .idle_count(idle0), .state(st0),
    .halt_reason(rsn0), .halt_code(code0), .halted(hl0), .halted_pulse(pl0)
  );

  retire_monitor #(
    .WAYS(2), .CNT_W(4), .WATCHDOG(0), .DRAIN_CYCLES(0), .IGNORE_MASK(16'h0021)
  ) u1 (
    .clock(clk), .reset(rst_n), .mon(bus1.slave),
    .cycle_count(cyc1), .instr_count(ins1), .idle_count(idle1), .state(st1),
    .halt_reason(rsn1), .halt_code(code1), .halted(hl1), .halted_pulse(pl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: st 0 run, 1 drain, 2 halted
  typedef struct packed {
    int          st;
    int          drain;
    logic [63:0] cyc;
    logic [63:0] ins;
    int          idle;
    int          reason;
    int          code;
    int          pulse;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_step(mdl_t m, int pop, int err, bit ext,
                                    int wd, int dr, logic [63:0] cmax,
                                    logic [15:0] mk);
    mdl_t n;
    n = m;
    n.pulse = 0;
    if (m.st == 2) return n;
    n.cyc = (m.cyc == cmax) ? cmax : m.cyc + 64'd1;
    n.ins = ((cmax - m.ins) < 64'(pop)) ? cmax : m.ins + 64'(pop);
    if (m.st == 1) begin
      if (m.drain == 1) begin
        n.st = 2;
        n.pulse = 1;
      end else begin
        n.drain = m.drain - 1;
      end
      return n;
    end
    n.idle = (pop != 0) ? 0 : ((m.idle < wd) ? m.idle + 1 : wd);
    if (mk[err] == 1'b0) begin
      n.reason = 1; n.code = err;
    end else if (wd != 0 && pop == 0 && m.idle == wd - 1) begin
      n.reason = 2; n.code = 0;
    end else if (ext) begin
      n.reason = 3; n.code = 0;
    end else begin
      return n;
    end
    if (dr == 0) begin
      n.st = 2;
      n.pulse = 1;
    end else begin
      n.st = 1;
      n.drain = dr;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("u0.cycle",  cyc0, m0.cyc);
    chk("u0.instr",  ins0, m0.ins);
    chk("u0.idle",   64'(idle0), 64'(m0.idle));
    chk("u0.state",  64'(st0),   64'(m0.st));
    chk("u0.reason", 64'(rsn0),  64'(m0.reason));
    chk("u0.code",   64'(code0), 64'(m0.code));
    chk("u0.halted", 64'(hl0),   64'(m0.st == 2));
    chk("u0.pulse",  64'(pl0),   64'(m0.pulse));
    chk("u1.cycle",  64'(cyc1),  m1.cyc);
    chk("u1.instr",  64'(ins1),  m1.ins);
    chk("u1.idle",   64'(idle1), 64'(m1.idle));
    chk("u1.state",  64'(st1),   64'(m1.st));
    chk("u1.reason", 64'(rsn1),  64'(m1.reason));
    chk("u1.code",   64'(code1), 64'(m1.code));
    chk("u1.halted", 64'(hl1),   64'(m1.st == 2));
    chk("u1.pulse",  64'(pl1),   64'(m1.pulse));
  endtask

  task automatic set_inputs(input logic [1:0] cv, input logic [3:0] err, input logic ext);
    bus0.commit_valid = cv; bus0.error_status = err; bus0.ext_halt = ext;
    bus1.commit_valid = cv; bus1.error_status = err; bus1.ext_halt = ext;
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next falling edge
  task automatic tick(input logic [1:0] cv, input logic [3:0] err, input logic ext);
    set_inputs(cv, err, ext);
    @(posedge clk);
    m0 = mdl_step(m0, $countones(cv), int'(err), ext, 8, 4, {64{1'b1}}, 16'h0021);
    m1 = mdl_step(m1, $countones(cv), int'(err), ext, 0, 0, 64'd15, 16'h0021);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_inputs(2'b00, 4'd0, 1'b0);
    rst_n = 1'b0;
    #2;
    m0 = '0;
    m1 = '0;
    compare_all();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] rnd_retire();
    return 2'($urandom_range(1, 3));
  endfunction

  initial begin
    int drain_pop;
    logic [1:0] cv;
    logic [3:0] err;
    logic ext;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    m0 = '0;
    m1 = '0;
    set_inputs(2'b00, 4'd0, 1'b0);

    // Error halt after steady dual retire; narrow counter saturates
    do_reset();
    for (int i = 0; i < 10; i++) tick(2'b11, 4'd0, 1'b0);
    chk("s1.instr20", ins0, 64'd20);
    chk("s1.sat15", 64'(ins1), 64'd15);
    cv = rnd_retire();
    drain_pop = $countones(cv);
    tick(cv, 4'd2, 1'b0);
    chk("s1.drain_state", 64'(st0), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cv = 2'($urandom_range(0, 3));
      drain_pop += $countones(cv);
      tick(cv, 4'd0, 1'b0);
    end
    chk("s1.halted", 64'(st0), 64'd2);
    chk("s1.pulse", 64'(pl0), 64'd1);
    chk("s1.reason", 64'(rsn0), 64'd1);
    chk("s1.code", 64'(code0), 64'd2);
    chk("s1.instr", ins0, 64'(20 + drain_pop));
    tick(2'b11, 4'd0, 1'b0);
    chk("s1.pulse_once", 64'(pl0), 64'd0);
    chk("s1.frozen", ins0, 64'(20 + drain_pop));
    $display("scenario error_halt checks=%0d errors=%0d", checks, errors);

    // Watchdog fires on the 8th idle edge
    do_reset();
    for (int i = 0; i < 7; i++) tick(2'b00, 4'd0, 1'b0);
    chk("s2.idle7", 64'(idle0), 64'd7);
    chk("s2.run", 64'(st0), 64'd0);
    tick(2'b00, 4'd0, 1'b0);
    chk("s2.wd_drain", 64'(st0), 64'd1);
    chk("s2.wd_reason", 64'(rsn0), 64'd2);
    for (int i = 0; i < 4; i++) tick(2'b00, 4'd0, 1'b0);
    chk("s2.wd_cycles", cyc0, 64'd12);
    $display("scenario watchdog checks=%0d errors=%0d", checks, errors);

    // A single retire on cycle 7 restarts the idle run
    do_reset();
    for (int i = 0; i < 6; i++) tick(2'b00, 4'd0, 1'b0);
    tick(2'b01, 4'd0, 1'b0);
    chk("s3.idle0", 64'(idle0), 64'd0);
    for (int i = 0; i < 7; i++) tick(2'b00, 4'd0, 1'b0);
    chk("s3.no_halt", 64'(st0), 64'd0);
    $display("scenario watchdog_rescue checks=%0d errors=%0d", checks, errors);

    // Masked code held, then an unmasked one
    do_reset();
    for (int i = 0; i < 100; i++) tick(rnd_retire(), 4'd5, 1'b0);
    chk("s4.masked_run0", 64'(st0), 64'd0);
    chk("s4.masked_run1", 64'(st1), 64'd0);
    tick(rnd_retire(), 4'd3, 1'b0);
    chk("s4.code3", 64'(code0), 64'd3);
    chk("s4.u1_halt", 64'(st1), 64'd2);
    $display("scenario masked_error checks=%0d errors=%0d", checks, errors);

    // External halt at cycle 5 with no drain window
    do_reset();
    for (int i = 0; i < 4; i++) tick(rnd_retire(), 4'd0, 1'b0);
    tick(rnd_retire(), 4'd0, 1'b1);
    chk("s5.cyc5", 64'(cyc1), 64'd5);
    chk("s5.reason3", 64'(rsn1), 64'd3);
    chk("s5.halted", 64'(hl1), 64'd1);
    $display("scenario ext_halt checks=%0d errors=%0d", checks, errors);

    // Error and external together, second error during drain
    do_reset();
    for (int i = 0; i < 3; i++) tick(rnd_retire(), 4'd0, 1'b0);
    tick(rnd_retire(), 4'd4, 1'b1);
    tick(rnd_retire(), 4'd7, 1'b0);
    chk("s6.reason", 64'(rsn0), 64'd1);
    chk("s6.code", 64'(code0), 64'd4);
    $display("scenario sticky_cause checks=%0d errors=%0d", checks, errors);

    // Asynchronous reset in the middle of the drain window
    do_reset();
    for (int i = 0; i < 3; i++) tick(rnd_retire(), 4'd0, 1'b0);
    tick(rnd_retire(), 4'd0, 1'b1);
    tick(rnd_retire(), 4'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    m0 = '0;
    m1 = '0;
    chk("s7.async_cyc", cyc0, 64'd0);
    chk("s7.async_state", 64'(st0), 64'd0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(rnd_retire(), 4'd0, 1'b0);
    chk("s7.restart", cyc0, 64'd3);
    $display("scenario async_reset checks=%0d errors=%0d", checks, errors);

    // Randomised runs
    for (int r = 0; r < 20; r++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        if (r % 3 == 0) cv = ($urandom_range(0, 9) == 0) ? rnd_retire() : 2'b00;
        else            cv = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 30) == 0) err = 4'($urandom_range(0, 15));
        else                            err = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd5;
        ext = ($urandom_range(0, 40) == 0);
        tick(cv, err, ext);
      end
      $display("scenario random_%0d checks=%0d errors=%0d", r, checks, errors);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
